// File: rtl/mem_test_pkg.sv
// Shared definitions for the mem_test run sequencer: FSM states, default
// watchdog limit and the data patterns the memory tester writes.
package mem_test_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } mts_state_e;

    localparam int MEM_TEST_TIMEOUT_DEFAULT = 8192;

    localparam logic [7:0] MEM_TEST_PASS_DATA = 8'h55;
    localparam logic [7:0] MEM_TEST_FAIL_DATA = 8'hAA;

endpackage

// File: rtl/mem_test_wdog.sv
// Watchdog counter for the RUN phase: cleared by clr, counts while en, and
// flags expire on the last allowed cycle.
module mem_test_wdog
    import mem_test_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = MEM_TEST_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt_q;

    assign expire = en && (cnt_q == LAST);

    // Counter parks on LAST so it can never wrap past the limit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && !expire) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/mem_test_seq.sv
// Run sequencer for mem_test: holds the tester in reset, releases it for a
// run, collects pass/fail with a watchdog, counts runs and supports looping.
module mem_test_seq
    import mem_test_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = MEM_TEST_TIMEOUT_DEFAULT,
    parameter int RST_CYCLES     = 2,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             loop,
    input  logic             abort,
    input  logic             dut_result,
    input  logic             dut_fin,
    output logic             dut_rstn,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [CNT_W-1:0] run_cnt,
    output logic [CNT_W-1:0] fail_cnt
);

    localparam int RW = $clog2(RST_CYCLES);
    localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);

    mts_state_e       state_q, state_d;
    logic [RW-1:0]    rcnt_q, rcnt_d;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
    logic             pass_q, pass_d;
    logic             timeout_q, timeout_d;
    logic             dut_rstn_q, busy_q, done_q;
    logic             wd_expire;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    mem_test_wdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk   (clk),
        .reset (reset),
        .clr   (state_q == CLEAR),
        .en    (state_q == RUN),
        .expire(wd_expire)
    );

    always_comb begin
        state_d    = state_q;
        rcnt_d     = rcnt_q;
        run_cnt_d  = run_cnt_q;
        fail_cnt_d = fail_cnt_q;
        pass_d     = pass_q;
        timeout_d  = timeout_q;

        if (abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        run_cnt_d  = '0;
                        fail_cnt_d = '0;
                        pass_d     = 1'b0;
                        timeout_d  = 1'b0;
                        rcnt_d     = '0;
                        state_d    = CLEAR;
                    end
                end
                CLEAR: begin
                    if (rcnt_q == RST_LAST) begin
                        state_d = RUN;
                    end else begin
                        rcnt_d = rcnt_q + RW'(1);
                    end
                end
                RUN: begin
                    // A finishing tester takes priority over a simultaneous expiry.
                    if (dut_fin) begin
                        pass_d    = dut_result;
                        run_cnt_d = sat_inc(run_cnt_q);
                        if (!dut_result) begin
                            fail_cnt_d = sat_inc(fail_cnt_q);
                        end
                        state_d = DONE;
                    end else if (wd_expire) begin
                        pass_d     = 1'b0;
                        timeout_d  = 1'b1;
                        run_cnt_d  = sat_inc(run_cnt_q);
                        fail_cnt_d = sat_inc(fail_cnt_q);
                        state_d    = DONE;
                    end
                end
                DONE: begin
                    rcnt_d  = '0;
                    state_d = loop ? CLEAR : IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            rcnt_q     <= '0;
            run_cnt_q  <= '0;
            fail_cnt_q <= '0;
            pass_q     <= 1'b0;
            timeout_q  <= 1'b0;
            dut_rstn_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rcnt_q     <= rcnt_d;
            run_cnt_q  <= run_cnt_d;
            fail_cnt_q <= fail_cnt_d;
            pass_q     <= pass_d;
            timeout_q  <= timeout_d;
            // Strobes are decoded from the next state so they align with it.
            dut_rstn_q <= (state_d == RUN);
            busy_q     <= (state_d != IDLE);
            done_q     <= (state_d == DONE);
        end
    end

    assign dut_rstn = dut_rstn_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign timeout  = timeout_q;
    assign run_cnt  = run_cnt_q;
    assign fail_cnt = fail_cnt_q;

endmodule

// File: tb/tb_mem_test_seq.sv
// Directed bench for mem_test_seq with a behavioural stand-in for mem_test
// that raises fin a programmable number of cycles after release.
module tb_mem_test_seq;

    localparam int TMO   = 8192;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             loop;
    logic             abort;
    logic             dut_result;
    logic             dut_fin;
    logic             dut_rstn;
    logic             busy;
    logic             done;
    logic             pass;
    logic             timeout;
    logic [CNT_W-1:0] run_cnt;
    logic [CNT_W-1:0] fail_cnt;

    int total = 0;
    int bad   = 0;

    // Stand-in tester configuration.
    logic stub_en;
    logic stub_res;
    int   stub_len;
    int   stub_cyc;

    mem_test_seq #(
        .TIMEOUT_CYCLES(TMO),
        .RST_CYCLES    (2),
        .CNT_W         (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (rst_n),
        .start     (start),
        .loop      (loop),
        .abort     (abort),
        .dut_result(dut_result),
        .dut_fin   (dut_fin),
        .dut_rstn  (dut_rstn),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .timeout   (timeout),
        .run_cnt   (run_cnt),
        .fail_cnt  (fail_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Like mem_test, the stand-in updates on the falling edge and holds fin.
    always @(negedge clk) begin
        if (!dut_rstn) begin
            stub_cyc   <= 0;
            dut_fin    <= 1'b0;
            dut_result <= 1'b1;
        end else begin
            stub_cyc <= stub_cyc + 1;
            if (stub_en && (stub_cyc + 1 == stub_len)) begin
                dut_fin    <= 1'b1;
                dut_result <= stub_res;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Pulse start and check the reset hold-off: two cycles low, then release.
    task automatic start_run(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy_t1"}, busy, 1);
        chk({tag, "_rstn_t1"}, dut_rstn, 0);
        tick();
        chk({tag, "_rstn_t2"}, dut_rstn, 0);
        tick();
        chk({tag, "_rstn_t3"}, dut_rstn, 1);
    endtask

    task automatic wait_done(input int budget, output int lat);
        lat = 0;
        while (1) begin
            tick();
            lat++;
            if (done) break;
            if (lat >= budget) begin
                lat = -1;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int ndone;
        int since;
        int gap;

        rst_n    = 1'b0;
        start    = 1'b0;
        loop     = 1'b0;
        abort    = 1'b0;
        stub_en  = 1'b1;
        stub_res = 1'b1;
        stub_len = 20;

        // Reset state
        tick();
        tick();
        chk("rst_dut_rstn", dut_rstn, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_run_cnt", run_cnt, 0);
        chk("rst_fail_cnt", fail_cnt, 0);
        rst_n = 1'b1;
        tick();
        tick();

        // Healthy run: fin after 20 RUN cycles
        start_run("ok");
        wait_done(200, lat);
        chk("ok_latency", lat, 20);
        chk("ok_pass", pass, 1);
        chk("ok_run_cnt", run_cnt, 1);
        chk("ok_fail_cnt", fail_cnt, 0);
        chk("ok_timeout", timeout, 0);
        tick();
        chk("ok_done_pulse", done, 0);
        chk("ok_busy_end", busy, 0);

        // Failing run
        stub_res = 1'b0;
        stub_len = 30;
        start_run("bad");
        wait_done(200, lat);
        chk("bad_latency", lat, 30);
        chk("bad_pass", pass, 0);
        chk("bad_run_cnt", run_cnt, 1);
        chk("bad_fail_cnt", fail_cnt, 1);
        chk("bad_timeout", timeout, 0);
        tick();
        chk("bad_busy_end", busy, 0);

        // Watchdog timeout: fin never rises
        stub_en  = 1'b0;
        stub_res = 1'b1;
        start_run("tmo");
        wait_done(TMO + 100, lat);
        chk("tmo_latency", lat, TMO);
        chk("tmo_timeout", timeout, 1);
        chk("tmo_pass", pass, 0);
        chk("tmo_run_cnt", run_cnt, 1);
        chk("tmo_fail_cnt", fail_cnt, 1);
        tick();
        chk("tmo_busy_end", busy, 0);

        // Loop three passing runs, dropping loop on the third done
        stub_en  = 1'b1;
        stub_res = 1'b1;
        stub_len = 10;
        loop     = 1'b1;
        start_run("loop");
        ndone = 0;
        since = -1;
        gap   = -1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (since >= 0) since++;
            if (dut_rstn && gap < 0 && since >= 0) gap = since;
            if (done) begin
                ndone++;
                if (ndone == 1) since = 0;
                if (ndone == 3) begin
                    loop = 1'b0;
                    break;
                end
            end
        end
        chk("loop_ndone", ndone, 3);
        chk("loop_gap", gap, 3);
        chk("loop_run_cnt", run_cnt, 3);
        chk("loop_fail_cnt", fail_cnt, 0);
        chk("loop_timeout", timeout, 0);
        tick();
        chk("loop_busy_end", busy, 0);
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done) ndone++;
        end
        chk("loop_no_extra_done", ndone, 0);

        // start together with abort in IDLE: stays idle, counters untouched
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("sa_busy", busy, 0);
        chk("sa_run_cnt", run_cnt, 3);
        tick();
        chk("sa_busy_later", busy, 0);

        // Abort after 1000 RUN cycles
        stub_en = 1'b0;
        start_run("abt");
        for (int i = 0; i < 999; i++) tick();
        chk("abt_busy_before", busy, 1);
        chk("abt_rstn_before", dut_rstn, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abt_busy", busy, 0);
        chk("abt_rstn", dut_rstn, 0);
        chk("abt_done", done, 0);
        chk("abt_run_cnt", run_cnt, 0);
        chk("abt_timeout", timeout, 0);
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) ndone++;
        end
        chk("abt_no_done", ndone, 0);

        // Saturation: 260 looped failing runs
        stub_en  = 1'b1;
        stub_res = 1'b0;
        stub_len = 1;
        loop     = 1'b1;
        start_run("sat");
        ndone = 0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (done) begin
                ndone++;
                if (ndone == 260) begin
                    stub_en = 1'b0;
                    break;
                end
            end
        end
        chk("sat_ndone", ndone, 260);
        chk("sat_run_cnt", run_cnt, 255);
        chk("sat_fail_cnt", fail_cnt, 255);
        chk("sat_pass", pass, 0);

        // Asynchronous reset in the middle of the next looped run
        tick();
        tick();
        tick();
        chk("ar_busy_before", busy, 1);
        chk("ar_rstn_before", dut_rstn, 1);
        chk("ar_run_cnt_before", run_cnt, 255);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_dut_rstn", dut_rstn, 0);
        chk("ar_busy", busy, 0);
        chk("ar_done", done, 0);
        chk("ar_pass", pass, 0);
        chk("ar_timeout", timeout, 0);
        chk("ar_run_cnt", run_cnt, 0);
        chk("ar_fail_cnt", fail_cnt, 0);
        loop = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("ar_idle_after", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
